// File: rtl/fifo_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx_pkg
// Purpose  : Shared definitions for the FIFO-fed 8N1 UART transmitter:
//            FSM state encoding, frame geometry constants and a helper
//            that sizes the baud counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fifo_uart_tx_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Counter width for a 0..clks-1 count; never narrower than one bit.
  function automatic int baud_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_cnt
// Purpose  : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; tick
//            is high in the last cycle of every bit period.
// Ports    : clk   - clock, rising edge
//            reset - asynchronous active-high reset
//            clear - hold the count at zero
//            tick  - terminal-count flag (combinational from the count)
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_cnt
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int                 c_cnt_w = baud_width(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_one;
    end
  end

  assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : 8N1 UART transmitter that pulls bytes from an upstream FIFO.
//            A byte is read whenever the line is idle or the current stop
//            bit is ending, so queued bytes go out back-to-back.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous active-high reset
//            fifo_empty - upstream FIFO empty flag
//            fifo_data  - upstream FIFO read data (valid while fifo_rd high)
//            fifo_rd    - one-cycle read strobe (combinational)
//            txd        - serial output, idle high, registered
//            busy       - frame in progress
//            frame_done - pulse in the final cycle of each stop bit
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       txd,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [2:0] c_last_bit = 3'(DATA_BITS - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic       w_tick;
  logic       w_clear;
  logic       w_last_stop;
  logic       w_rd;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_txd;

  // Counter sits at zero while idle, so a frame always begins on a fresh
  // bit period; between back-to-back frames it simply wraps.
  assign w_clear = (r_state == IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(w_clear),
    .tick (w_tick)
  );

  assign w_last_stop = (r_state == STOP) && w_tick;
  assign w_rd        = ((r_state == IDLE) || w_last_stop) && !fifo_empty && !reset;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_rd) w_next_state = START;
      START:   if (w_tick) w_next_state = DATA;
      DATA:    if (w_tick && (r_bit_cnt == c_last_bit)) w_next_state = STOP;
      STOP:    if (w_tick) w_next_state = w_rd ? START : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    fifo_rd    = w_rd;
    busy       = (r_state != IDLE);
    frame_done = w_last_stop;
  end

  // Datapath: txd is loaded one edge ahead with the level of the next bit,
  // so the line changes exactly on bit boundaries from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_txd     <= 1'b1;
    end else if (w_rd) begin
      r_shift   <= fifo_data;
      r_bit_cnt <= '0;
      r_txd     <= 1'b0;
    end else if (w_tick) begin
      case (r_state)
        START: r_txd <= r_shift[0];
        DATA: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          r_shift   <= r_shift >> 1;
          r_txd     <= (r_bit_cnt == c_last_bit) ? 1'b1 : r_shift[1];
        end
        default: r_txd <= 1'b1;
      endcase
    end
  end

  assign txd = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4. The
//            upstream FIFO is a queue; a frame-level model predicts every
//            output each cycle and a line decoder recovers transmitted bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       txd;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .txd       (txd),
    .busy      (busy),
    .frame_done(frame_done)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] pend_q[$];
  logic       rd_prev = 1'b0;
  logic       release_reset = 1'b0;
  int         rd_cyc[$];
  logic [7:0] rd_byte[$];
  int         fd_cyc[$];

  // Frame-level model: position inside the current 40-cycle frame, -1 idle
  int         m_idx = -1;
  logic [9:0] m_frame = '0;

  // Line decoder
  logic       dec_active = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = '0;
  logic [7:0] dec_q[$];
  logic       prev_txd = 1'b1;

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;   // bits[i] = level of the i-th transmitted bit
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    logic e_txd, e_busy, e_fd, e_rd, in_frame;
    int   k;
    @(posedge clk);
    #1;
    if (release_reset) begin
      reset = 1'b0;
      release_reset = 1'b0;
    end
    if (rd_prev && fifo_q.size() > 0) void'(fifo_q.pop_front());
    while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    @(negedge clk);
    cyc++;
    in_frame = (m_idx >= 0);
    e_txd  = in_frame ? m_frame[m_idx / CPB] : 1'b1;
    e_busy = in_frame;
    e_fd   = in_frame && (m_idx == FRAME_CYC - 1);
    e_rd   = (!in_frame || (m_idx == FRAME_CYC - 1)) && !fifo_empty && !reset;
    check("txd", txd, e_txd);
    check("busy", busy, e_busy);
    check("frame_done", frame_done, e_fd);
    check("fifo_rd", fifo_rd, e_rd);
    rd_prev = fifo_rd;
    if (fifo_rd) begin
      rd_cyc.push_back(cyc);
      rd_byte.push_back(fifo_data);
    end
    if (frame_done) fd_cyc.push_back(cyc);
    if (reset) m_idx = -1;
    else if (e_rd) begin
      m_idx   = 0;
      m_frame = {1'b1, fifo_data, 1'b0};
    end else if (in_frame) m_idx = (m_idx == FRAME_CYC - 1) ? -1 : m_idx + 1;
    // decode the serial line by mid-bit sampling
    if (reset) dec_active = 1'b0;
    else if (!dec_active) begin
      if (prev_txd && !txd) begin
        dec_active = 1'b1;
        dec_cnt = 0;
      end
    end else dec_cnt++;
    if (dec_active && (dec_cnt % CPB == CPB / 2)) begin
      k = dec_cnt / CPB;
      if (k >= 1 && k <= 8) dec_byte[k-1] = txd;
      if (k == 9) begin
        check("dec_stop", txd, 1'b1);
        dec_q.push_back(dec_byte);
        dec_active = 1'b0;
      end
    end
    prev_txd = txd;
  endtask

  task automatic wait_idle(input int bound);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      if (m_idx < 0 && fifo_q.size() == 0 && pend_q.size() == 0 && !busy) done = 1;
      else cycle();
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle timeout at cycle %0d: busy=%0b expected idle", cyc, busy);
    end
  endtask

  initial begin
    int r;
    tbl[0] = '{8'hA5, 10'b1101001010};
    tbl[1] = '{8'h00, 10'b1000000000};
    tbl[2] = '{8'hFF, 10'b1111111110};
    tbl[3] = '{8'h3C, 10'b1001111000};
    tbl[4] = '{8'h81, 10'b1100000010};

    reset = 1'b1;
    fifo_empty = 1'b1;
    fifo_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_fifo_rd", fifo_rd, 1'b0);

    // data waiting during reset must not be read until reset releases
    pend_q.push_back(8'hC3);
    cycle();
    cycle();
    check("rd_in_reset", fifo_rd, 1'b0);
    release_reset = 1'b1;
    cycle();
    check("first_rd_after_reset", fifo_rd, 1'b1);
    wait_idle(100);

    // empty hold
    rd_cyc.delete();
    repeat (100) cycle();
    check("empty_hold_reads", rd_cyc.size(), 0);

    // table-driven single frames
    foreach (tbl[t]) begin
      rd_cyc.delete();
      fd_cyc.delete();
      pend_q.push_back(tbl[t].data);
      cycle();
      check("tbl_rd", rd_cyc.size(), 1);
      if (rd_cyc.size() == 1) begin
        r = rd_cyc[0];
        for (int k = 0; k < FRAME_CYC; k++) begin
          cycle();
          if ((cyc - r - 1) % CPB == CPB / 2)
            check("tbl_bit", txd, tbl[t].bits[(cyc - r - 1) / CPB]);
        end
        cycle();
        check("tbl_busy_after", busy, 1'b0);
        check("tbl_rd_count", rd_cyc.size(), 1);
        check("tbl_fd_count", fd_cyc.size(), 1);
        if (fd_cyc.size() == 1) check("tbl_fd_time", fd_cyc[0] - r, FRAME_CYC);
      end
      wait_idle(60);
    end

    // back-to-back
    rd_cyc.delete();
    fd_cyc.delete();
    pend_q.push_back(8'h00);
    pend_q.push_back(8'hFF);
    pend_q.push_back(8'h3C);
    wait_idle(200);
    check("b2b_reads", rd_cyc.size(), 3);
    check("b2b_frames", fd_cyc.size(), 3);
    if (rd_cyc.size() == 3 && fd_cyc.size() == 3) begin
      check("b2b_gap1", rd_cyc[1] - rd_cyc[0], FRAME_CYC);
      check("b2b_gap2", rd_cyc[2] - rd_cyc[1], FRAME_CYC);
      check("b2b_total", fd_cyc[2] - rd_cyc[0], 3 * FRAME_CYC);
    end

    // reset mid-frame, asserted between edges
    rd_cyc.delete();
    pend_q.push_back(8'h55);
    cycle();
    check("rst_mid_rd", rd_cyc.size(), 1);
    repeat (16) cycle();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_txd", txd, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_rd_low", fifo_rd, 1'b0);
    m_idx = -1;
    rd_prev = 1'b0;
    repeat (5) cycle();
    release_reset = 1'b1;
    repeat (10) cycle();
    check("rst_no_resume", rd_cyc.size(), 1);
    pend_q.push_back(8'h5A);
    wait_idle(100);
    check("rst_new_frame", rd_cyc.size(), 2);

    // late refill in cycle 20 of a frame
    rd_cyc.delete();
    pend_q.push_back(8'hA5);
    cycle();
    repeat (19) cycle();
    pend_q.push_back(8'h96);
    wait_idle(150);
    check("late_reads", rd_cyc.size(), 2);
    if (rd_cyc.size() == 2) check("late_gap", rd_cyc[1] - rd_cyc[0], FRAME_CYC);

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) pend_q.push_back(8'($urandom));
      repeat ($urandom_range(0, 50)) cycle();
    end
    wait_idle(2000);

    // 16 bytes through the FIFO, decoded off the line
    dec_q.delete();
    rd_byte.delete();
    for (int i = 0; i < 16; i++) pend_q.push_back(8'(i));
    wait_idle(16 * FRAME_CYC + 50);
    check("int_reads", rd_byte.size(), 16);
    check("int_decoded", dec_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < dec_q.size()) check("int_dec_byte", dec_q[i], i);
      if (i < rd_byte.size()) check("int_rd_byte", rd_byte[i], i);
    end
    check("int_empty", fifo_empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port fifo_empty, input, 1, the upstream 8x16 FIFO's empty flag.
REQ-005 The block SHALL have port fifo_data, input, 8, the upstream FIFO read data, valid combinationally in the cycle fifo_rd is high.
REQ-006 The block SHALL have port fifo_rd, output, 1, the one-cycle read strobe to the FIFO.
REQ-007 The block SHALL have port txd, output, 1, the serial line; idle level is high.
REQ-008 The block SHALL have port busy, output, 1, high whenever a frame is in progress (state not IDLE).
REQ-009 The block SHALL have port frame_done, output, 1, a one-cycle pulse in the final cycle of each stop bit.

Function
REQ-010 Frame format SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1); 10*CLKS_PER_BIT cycles per frame.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-012 fifo_rd SHALL be combinational: high iff (state==IDLE or last cycle of STOP) and fifo_empty==0 and reset==0.
REQ-013 In any cycle with fifo_rd=1, fifo_data SHALL be captured into an 8-bit shift register on that clock edge, and the next state SHALL be START.
REQ-014 fifo_rd SHALL never be high for two consecutive cycles, and never while fifo_empty=1.
REQ-015 Latency: txd SHALL go low on the clock edge ending the fifo_rd cycle.
REQ-016 A baud counter SHALL count 0..CLKS_PER_BIT-1, with width clog2(CLKS_PER_BIT); each bit period ends when it reaches CLKS_PER_BIT-1, after which it wraps to 0.
REQ-017 START->DATA SHALL occur at the end of one bit period.
REQ-018 In DATA, a 3-bit counter SHALL index bits 0..7; DATA->STOP SHALL occur at the end of bit 7.
REQ-019 STOP->START (back-to-back, no idle gap) SHALL occur if fifo_empty=0 in the last STOP cycle; otherwise STOP->IDLE.
REQ-020 In IDLE with fifo_empty=1, the block SHALL hold txd=1 and busy=0, and keep the counters at 0.
REQ-021 txd SHALL be driven from a register (glitch-free).
REQ-022 Changes to fifo_empty mid-frame SHALL have no effect until the last STOP cycle.

Reset
REQ-023 Reset SHALL, asynchronously and immediately: set state=IDLE, txd=1, busy=0, frame_done=0, and clear the baud counter, bit counter and shift register to 0; fifo_rd SHALL be 0 while reset is high.
REQ-024 Reset mid-frame SHALL abort the frame with no resumption; the first frame after reset deassertion SHALL start only via REQ-012.

Structure
REQ-025 A shared package SHALL hold the state enum (IDLE, START, DATA, STOP), DATA_BITS=8, and FRAME_BITS=10.
REQ-026 The baud counter SHALL be a sub-module uart_baud_cnt (inputs clk, reset, clear; output tick at terminal count), instantiated once.

Verification (CLKS_PER_BIT=4)
REQ-027 Single byte: fifo_empty=0 for one read, fifo_data=8'hA5 -> one fifo_rd pulse; txd = 0,1,0,1,0,0,1,0,1,1 per 4-cycle bit; frame_done pulses at cycle 40; then busy=0.
REQ-028 Back-to-back: three bytes 8'h00, 8'hFF, 8'h3C available -> three fifo_rd pulses exactly 40 cycles apart; no high-idle gap between the stop bit and the next start bit; 120 cycles total.
REQ-029 Empty hold: fifo_empty=1 for 100 cycles -> fifo_rd=0, txd=1, busy=0 throughout.
REQ-030 Reset mid-frame: assert reset in cycle 17 of a frame for 8'h55 (asynchronously, between edges) -> txd=1 and busy=0 before the next edge; after deassertion, a new frame starts only when fifo_empty=0.
REQ-031 Late refill: fifo_empty goes 1->0 in cycle 20 of a frame -> no fifo_rd until cycle 40, then a back-to-back frame follows.
REQ-032 Integration with the 16-deep FIFO: write 16 bytes 0..15 -> the serial stream decodes to 0..15 in order, and the FIFO's empty flag rises after the 16th fifo_rd.
